// File: rtl/pc_pkg.sv
// Shared fetch pre-decode definitions: opcodes, link registers, J-immediate extraction.
package pc_pkg;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [4:0] REG_RA  = 5'd1;
    localparam logic [4:0] REG_T0  = 5'd5;

    // 21-bit signed J-type offset; bit 0 is always zero.
    function automatic logic [20:0] jimm(input logic [31:0] instr);
        return {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx;
    logic [CW-1:0]    cnt_q, cnt_d;

    // ptr_q is the next free slot; the top lives one below it.
    assign top_idx = ptr_q - 1'b1;
    assign top_o   = mem_q[top_idx];
    assign count_o = cnt_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are not reset; count gates every use of them.
    always_ff @(posedge clk) begin
        if (!rst && !clear_i && push_i) mem_q[ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator with JAL pre-decode and return-address-stack prediction.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       StallF,
    input  logic [31:0]                InstrF,
    input  logic                       RedirectE,
    input  logic [WIDTH-1:0]           RedirectPCE,
    output logic [WIDTH-1:0]           PCF,
    output logic [WIDTH-1:0]           PCPlus4F,
    output logic                       PredTakenF,
    output logic [WIDTH-1:0]           PredTargetF,
    output logic                       FlushD,
    output logic [$clog2(RAS_DEPTH):0] RasCount
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] jal_tgt, ras_top;
    logic [20:0]      joff;
    logic [6:0]       opcode;
    logic [4:0]       rd, rs1;
    logic [2:0]       funct3;
    logic             is_jal, is_call, is_ret, ras_hit, advance;

    assign opcode = InstrF[6:0];
    assign rd     = InstrF[11:7];
    assign funct3 = InstrF[14:12];
    assign rs1    = InstrF[19:15];
    assign joff   = jimm(InstrF);

    assign is_jal  = (opcode == OP_JAL);
    assign is_call = is_jal && is_link(rd);
    // Only the canonical "jalr x0, 0(ra|t0)" is treated as a return.
    assign is_ret  = (opcode == OP_JALR) && (funct3 == 3'b000) && (rd == 5'd0)
                     && is_link(rs1) && (InstrF[31:20] == 12'd0);
    assign ras_hit = is_ret && (RasCount != '0);

    assign jal_tgt  = pc_q + {{(WIDTH-21){joff[20]}}, joff};
    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + WIDTH'(4);
    assign FlushD   = RedirectE;

    always_comb begin
        PredTakenF  = 1'b0;
        PredTargetF = PCPlus4F;
        if (is_jal) begin
            PredTakenF  = 1'b1;
            PredTargetF = jal_tgt;
        end else if (ras_hit) begin
            PredTakenF  = 1'b1;
            PredTargetF = ras_top;
        end
    end

    // A redirect discards the fetched instruction, so it must not touch the RAS.
    assign advance = !StallF && !RedirectE;

    always_comb begin
        pc_d = pc_q;
        if (RedirectE)    pc_d = RedirectPCE;
        else if (!StallF) pc_d = PredTargetF;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (RedirectE),
        .push_i      (advance && is_call),
        .push_data_i (PCPlus4F),
        .pop_i       (advance && ras_hit),
        .top_o       (ras_top),
        .count_o     (RasCount)
    );
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed vector bench for pc_gen_ras (RESET_PC=0x1000, RAS_DEPTH=4).
module tb_pc_gen_ras;
    logic        clk = 1'b0;
    logic        rst, StallF, RedirectE;
    logic [31:0] InstrF, RedirectPCE;
    logic [31:0] PCF, PCPlus4F, PredTargetF;
    logic        PredTakenF, FlushD;
    logic [2:0]  RasCount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen_ras #(.WIDTH(32), .RAS_DEPTH(4), .RESET_PC(32'h1000)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .InstrF(InstrF),
        .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .FlushD(FlushD), .RasCount(RasCount)
    );

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RET  = 32'h0000_8067; // jalr x0, 0(x1)
    localparam logic [31:0] JR4  = 32'h0040_8067; // jalr x0, 4(x1): not a return
    localparam logic [31:0] BEQ  = 32'h0000_0063;

    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc, instr;
        logic        chk;      // check combinational outputs before the edge
        logic        ptk, flush;
        logic [31:0] ptgt;
        logic [31:0] pcf;      // expected after the edge
        logic [2:0]  cnt;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rd_e,
                                input logic [31:0] rpc, input logic [31:0] ins,
                                input logic chk, input logic ptk, input logic fl,
                                input logic [31:0] ptgt, input logic [31:0] pcf,
                                input logic [2:0] cnt);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd_e; x.rpc = rpc; x.instr = ins;
        x.chk = chk; x.ptk = ptk; x.flush = fl; x.ptgt = ptgt; x.pcf = pcf; x.cnt = cnt;
        return x;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int idx);
        @(negedge clk);
        rst = x.rst; StallF = x.stall; RedirectE = x.redir;
        RedirectPCE = x.rpc; InstrF = x.instr;
        #1;
        if (x.chk) begin
            check("PredTakenF",  idx, {31'd0, PredTakenF}, {31'd0, x.ptk});
            check("PredTargetF", idx, PredTargetF, x.ptgt);
            check("FlushD",      idx, {31'd0, FlushD}, {31'd0, x.flush});
        end
        @(posedge clk);
        #1;
        check("PCF",      idx, PCF, x.pcf);
        check("PCPlus4F", idx, PCPlus4F, x.pcf + 32'd4);
        check("RasCount", idx, {29'd0, RasCount}, {29'd0, x.cnt});
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; RedirectE = 1'b0; RedirectPCE = '0; InstrF = NOP;

        //           rst  stl  red  rpc           instr                 chk ptk fl  ptgt          pcf           cnt
        v.push_back(mk(1, 0, 0, 32'h0,        NOP,                  0, 0, 0, 32'h0,        32'h1000,     0));
        v.push_back(mk(0, 0, 0, 32'h0,        NOP,                  1, 0, 0, 32'h1004,     32'h1004,     0));
        v.push_back(mk(0, 0, 0, 32'h0,        NOP,                  1, 0, 0, 32'h1008,     32'h1008,     0));
        v.push_back(mk(0, 0, 1, 32'h200,      NOP,                  1, 0, 1, 32'h100C,     32'h200,      0));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h40),    1, 1, 0, 32'h240,      32'h240,      1));
        v.push_back(mk(0, 0, 0, 32'h0,        NOP,                  1, 0, 0, 32'h244,      32'h244,      1));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 1, 0, 32'h204,      32'h204,      0));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 0, 0, 32'h208,      32'h208,      0));
        // five nested calls into a depth-4 stack
        v.push_back(mk(0, 0, 1, 32'h100,      NOP,                  1, 0, 1, 32'h20C,      32'h100,      0));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h100),   1, 1, 0, 32'h200,      32'h200,      1));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd5, 21'h100),   1, 1, 0, 32'h300,      32'h300,      2));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h100),   1, 1, 0, 32'h400,      32'h400,      3));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h100),   1, 1, 0, 32'h500,      32'h500,      4));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h100),   1, 1, 0, 32'h600,      32'h600,      4));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 1, 0, 32'h504,      32'h504,      3));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 1, 0, 32'h404,      32'h404,      2));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 1, 0, 32'h304,      32'h304,      1));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 1, 0, 32'h204,      32'h204,      0));
        v.push_back(mk(0, 0, 0, 32'h0,        RET,                  1, 0, 0, 32'h208,      32'h208,      0));
        // three stalled cycles with a call held in InstrF, then release
        v.push_back(mk(0, 1, 0, 32'h0,        jal(5'd1, 21'h40),    1, 1, 0, 32'h248,      32'h208,      0));
        v.push_back(mk(0, 1, 0, 32'h0,        jal(5'd1, 21'h40),    1, 1, 0, 32'h248,      32'h208,      0));
        v.push_back(mk(0, 1, 0, 32'h0,        jal(5'd1, 21'h40),    1, 1, 0, 32'h248,      32'h208,      0));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h40),    1, 1, 0, 32'h248,      32'h248,      1));
        // redirect beats stall and a same-cycle call, and clears the stack
        v.push_back(mk(0, 1, 1, 32'h800,      jal(5'd1, 21'h40),    1, 1, 1, 32'h288,      32'h800,      0));
        // address wrap and negative JAL offset
        v.push_back(mk(0, 0, 1, 32'hFFFFFFFC, NOP,                  1, 0, 1, 32'h804,      32'hFFFFFFFC, 0));
        v.push_back(mk(0, 0, 0, 32'h0,        NOP,                  1, 0, 0, 32'h0,        32'h0,        0));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd0, 21'h1FFFF8),1, 1, 0, 32'hFFFFFFF8, 32'hFFFFFFF8, 0));
        v.push_back(mk(0, 0, 0, 32'h0,        jal(5'd1, 21'h10),    1, 1, 0, 32'h8,        32'h8,        1));
        // non-return JALR and branch are never predicted
        v.push_back(mk(0, 0, 0, 32'h0,        JR4,                  1, 0, 0, 32'hC,        32'hC,        1));
        v.push_back(mk(0, 0, 0, 32'h0,        BEQ,                  1, 0, 0, 32'h10,       32'h10,       1));
        // reset wins over redirect and stall
        v.push_back(mk(1, 1, 1, 32'h800,      NOP,                  1, 0, 1, 32'h14,       32'h1000,     0));
        v.push_back(mk(0, 0, 0, 32'h0,        NOP,                  1, 0, 0, 32'h1004,     32'h1004,     0));

        foreach (v[i]) apply(v[i], i);

        // Hand sequence: build a stack entry, stall, then reset in the middle of the stall.
        @(negedge clk);
        InstrF = jal(5'd1, 21'h20); StallF = 1'b0;
        @(posedge clk); #1;
        check("seq_call_pc",  100, PCF, 32'h1024);
        check("seq_call_cnt", 100, {29'd0, RasCount}, 32'd1);
        @(negedge clk);
        InstrF = RET; StallF = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("seq_stall_pc",  101, PCF, 32'h1024);
        check("seq_stall_cnt", 101, {29'd0, RasCount}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("seq_rst_pc",  102, PCF, 32'h1000);
        check("seq_rst_cnt", 102, {29'd0, RasCount}, 32'd0);
        @(negedge clk);
        rst = 1'b0; StallF = 1'b0; #1;
        check("seq_ret_empty", 103, {31'd0, PredTakenF}, 32'd0);
        @(posedge clk); #1;
        check("seq_after_pc", 103, PCF, 32'h1004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
